// File: rtl/exp_share_arbiter.sv
// exp_share_arbiter: shares one fp16 exp datapath among NUM_REQ softmax lanes.
//
// A combinational round-robin arbiter grants one eligible lane per cycle. The
// granted operand is registered onto exp_in. A lane tag travels alongside the
// external datapath in a shift register of depth EXP_LAT+1. When the tag exits,
// the result on exp_out is registered onto resp_data/resp_valid for the issuing
// lane. Per-lane outstanding counters cap in-flight requests at MAX_OUT.
//
// Parameters:
//   NUM_REQ  number of lanes (2..8)
//   EXP_LAT  exp datapath latency in cycles (0..8, 0 = combinational)
//   MAX_OUT  max in-flight requests per lane (1..15)
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   req_valid/req_data      per-lane request and fp16 operand (lane i at [16i+15:16i])
//   req_ready               one-hot grant (combinational)
//   exp_in/exp_in_valid     registered operand to the exp datapath
//   exp_out                 exp datapath result
//   resp_valid/resp_data    registered one-hot lane select and fp16 result
// Optional (macro EXP_SHARE_STATS_EN):
//   stat_issued             saturating count of grants
//   stat_stall              saturating count of cycles with requests but no grant
module exp_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned EXP_LAT = 2,
  parameter int unsigned MAX_OUT = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [16*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [15:0]            exp_in,
  output logic                   exp_in_valid,
  input  logic [15:0]            exp_out,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [15:0]            resp_data
`ifdef EXP_SHARE_STATS_EN
  ,
  output logic [31:0]            stat_issued,
  output logic [31:0]            stat_stall
`endif
);

  localparam int unsigned PtrW  = $clog2(NUM_REQ);
  localparam int unsigned Depth = EXP_LAT + 1;
  localparam logic [PtrW:0] NumReqW = (PtrW+1)'(NUM_REQ);
  localparam logic [3:0]    MaxOutW = 4'(MAX_OUT);

  logic [PtrW-1:0]    rr_ptr_q;
  logic [PtrW-1:0]    rr_ptr_d;
  logic [3:0]         out_cnt_q [NUM_REQ];
  logic [Depth-1:0]   tag_vld_q;
  logic [PtrW-1:0]    tag_id_q [Depth];
  logic [15:0]        exp_in_q;
  logic               exp_in_valid_q;
  logic [NUM_REQ-1:0] resp_valid_q;
  logic [NUM_REQ-1:0] resp_valid_d;
  logic [15:0]        resp_data_q;

  logic [NUM_REQ-1:0] eligible;
  logic               grant_any;
  logic [PtrW-1:0]    grant_idx;
  logic [PtrW:0]      scan_idx;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (out_cnt_q[i] < MaxOutW);
    end
  end

  // Scan lanes starting at rr_ptr; first eligible lane wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (PtrW+1)'(k);
      if (scan_idx >= NumReqW) begin
        scan_idx = scan_idx - NumReqW;
      end
      if (!grant_any && eligible[scan_idx[PtrW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx[PtrW-1:0];
      end
    end
    // req_ready is combinational, so it must be forced low while reset is held.
    if (reset) begin
      grant_any = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_any && (grant_idx == PtrW'(i));
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      rr_ptr_d = (grant_idx == PtrW'(NUM_REQ - 1)) ? '0 : grant_idx + PtrW'(1);
    end
  end

  // Decode the tag leaving the pipe into a one-hot lane select.
  always_comb begin
    resp_valid_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid_d[i] = tag_vld_q[Depth-1] && (tag_id_q[Depth-1] == PtrW'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q       <= '0;
      tag_vld_q      <= '0;
      exp_in_q       <= '0;
      exp_in_valid_q <= 1'b0;
      resp_valid_q   <= '0;
      resp_data_q    <= '0;
      for (int s = 0; s < Depth; s++) begin
        tag_id_q[s] <= '0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        out_cnt_q[i] <= '0;
      end
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      exp_in_valid_q <= grant_any;
      if (grant_any) begin
        exp_in_q <= req_data[{grant_idx, 4'b0000} +: 16];
      end
      // Bubble tags (valid=0) are pushed on idle cycles.
      tag_vld_q[0] <= grant_any;
      tag_id_q[0]  <= grant_idx;
      for (int s = 1; s < Depth; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
      resp_valid_q <= resp_valid_d;
      if (tag_vld_q[Depth-1]) begin
        resp_data_q <= exp_out;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && !resp_valid_q[i]) begin
          out_cnt_q[i] <= out_cnt_q[i] + 4'd1;
        end else if (!req_ready[i] && resp_valid_q[i]) begin
          out_cnt_q[i] <= out_cnt_q[i] - 4'd1;
        end
      end
    end
  end

  assign exp_in       = exp_in_q;
  assign exp_in_valid = exp_in_valid_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;

`ifdef EXP_SHARE_STATS_EN
  logic [31:0] stat_issued_q;
  logic [31:0] stat_stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (grant_any && (stat_issued_q != '1)) begin
        stat_issued_q <= stat_issued_q + 32'd1;
      end
      if ((|req_valid) && !grant_any && (stat_stall_q != '1)) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_exp_share_arbiter.sv
// Testbench for exp_share_arbiter: table-driven cycle vectors on a default
// instance (4 lanes, latency 2, 3 outstanding), plus hand-written sequences on
// a MAX_OUT=1 instance, an EXP_LAT=0 instance and a mid-flight reset.
module tb_exp_share_arbiter;

  typedef struct packed {
    logic [3:0]  rv;
    logic [3:0]  rdy;
    logic        eiv;
    logic [15:0] ei;
    logic [3:0]  rspv;
    logic [15:0] rspd;
  } vec_t;

  localparam int NV = 43;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  // Default instance
  logic [3:0]  rv_m;
  logic [63:0] rd_m;
  logic [3:0]  rdy_m;
  logic [15:0] ei_m;
  logic        eiv_m;
  logic [15:0] eo_m;
  logic [3:0]  rspv_m;
  logic [15:0] rspd_m;
  logic [15:0] s1_m = '0;
  logic [15:0] s2_m = '0;

  // MAX_OUT=1 instance
  logic [3:0]  rv_l;
  logic [63:0] rd_l;
  logic [3:0]  rdy_l;
  logic [15:0] ei_l;
  logic        eiv_l;
  logic [15:0] eo_l;
  logic [3:0]  rspv_l;
  logic [15:0] rspd_l;
  logic [15:0] s1_l = '0;
  logic [15:0] s2_l = '0;

  // EXP_LAT=0 instance
  logic [3:0]  rv_z;
  logic [63:0] rd_z;
  logic [3:0]  rdy_z;
  logic [15:0] ei_z;
  logic        eiv_z;
  logic [15:0] eo_z;
  logic [3:0]  rspv_z;
  logic [15:0] rspd_z;

`ifdef EXP_SHARE_STATS_EN
  logic [31:0] iss_m, stl_m, iss_l, stl_l, iss_z, stl_z;
`endif

  vec_t vecs [NV];

  // Stand-in for the exp datapath: a few true fp16 exp values, otherwise a
  // distinct scramble so each lane's result is recognisable.
  function automatic logic [15:0] exp_model(input logic [15:0] x);
    case (x)
      16'h0000: return 16'h3C00;
      16'h3C00: return 16'h4170;
      16'hBC00: return 16'h35E3;
      default:  return x ^ 16'hA5A5;
    endcase
  endfunction

  function automatic vec_t mk(input logic [3:0] rv, input logic [3:0] rdy, input logic eiv,
                              input logic [15:0] ei, input logic [3:0] rspv,
                              input logic [15:0] rspd);
    vec_t v;
    v.rv = rv; v.rdy = rdy; v.eiv = eiv; v.ei = ei; v.rspv = rspv; v.rspd = rspd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    s1_m <= exp_model(ei_m);
    s2_m <= s1_m;
    s1_l <= exp_model(ei_l);
    s2_l <= s1_l;
  end
  assign eo_m = s2_m;
  assign eo_l = s2_l;
  assign eo_z = exp_model(ei_z);

  exp_share_arbiter #(.NUM_REQ(4), .EXP_LAT(2), .MAX_OUT(3)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (rv_m),
    .req_data     (rd_m),
    .req_ready    (rdy_m),
    .exp_in       (ei_m),
    .exp_in_valid (eiv_m),
    .exp_out      (eo_m),
    .resp_valid   (rspv_m),
    .resp_data    (rspd_m)
`ifdef EXP_SHARE_STATS_EN
    ,
    .stat_issued  (iss_m),
    .stat_stall   (stl_m)
`endif
  );

  exp_share_arbiter #(.NUM_REQ(4), .EXP_LAT(2), .MAX_OUT(1)) u_lim (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (rv_l),
    .req_data     (rd_l),
    .req_ready    (rdy_l),
    .exp_in       (ei_l),
    .exp_in_valid (eiv_l),
    .exp_out      (eo_l),
    .resp_valid   (rspv_l),
    .resp_data    (rspd_l)
`ifdef EXP_SHARE_STATS_EN
    ,
    .stat_issued  (iss_l),
    .stat_stall   (stl_l)
`endif
  );

  exp_share_arbiter #(.NUM_REQ(4), .EXP_LAT(0), .MAX_OUT(3)) u_lat0 (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (rv_z),
    .req_data     (rd_z),
    .req_ready    (rdy_z),
    .exp_in       (ei_z),
    .exp_in_valid (eiv_z),
    .exp_out      (eo_z),
    .resp_valid   (rspv_z),
    .resp_data    (rspd_z)
`ifdef EXP_SHARE_STATS_EN
    ,
    .stat_issued  (iss_z),
    .stat_stall   (stl_z)
`endif
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    rv_m = '0; rv_l = '0; rv_z = '0;
    rd_m = {16'h1234, 16'hBC00, 16'h3C00, 16'h0000};
    rd_l = {16'h0000, 16'hBC00, 16'h0000, 16'h0000};
    rd_z = {16'h0000, 16'h0000, 16'h0000, 16'h3C00};

    // Rows: {req_valid, req_ready, exp_in_valid, exp_in, resp_valid, resp_data}
    vecs[0]  = mk(4'h0, 4'h0, 1'b0, 16'h0000, 4'h0, 16'h0000);
    vecs[1]  = mk(4'h1, 4'h1, 1'b0, 16'h0000, 4'h0, 16'h0000);
    vecs[2]  = mk(4'h0, 4'h0, 1'b1, 16'h0000, 4'h0, 16'h0000);
    vecs[3]  = mk(4'h0, 4'h0, 1'b0, 16'h0000, 4'h0, 16'h0000);
    vecs[4]  = mk(4'h0, 4'h0, 1'b0, 16'h0000, 4'h0, 16'h0000);
    vecs[5]  = mk(4'h0, 4'h0, 1'b0, 16'h0000, 4'h1, 16'h3C00);
    vecs[6]  = mk(4'hF, 4'h2, 1'b0, 16'h0000, 4'h0, 16'h3C00);
    vecs[7]  = mk(4'hF, 4'h4, 1'b1, 16'h3C00, 4'h0, 16'h3C00);
    vecs[8]  = mk(4'hF, 4'h8, 1'b1, 16'hBC00, 4'h0, 16'h3C00);
    vecs[9]  = mk(4'hF, 4'h1, 1'b1, 16'h1234, 4'h0, 16'h3C00);
    vecs[10] = mk(4'hF, 4'h2, 1'b1, 16'h0000, 4'h2, 16'h4170);
    vecs[11] = mk(4'hF, 4'h4, 1'b1, 16'h3C00, 4'h4, 16'h35E3);
    vecs[12] = mk(4'hF, 4'h8, 1'b1, 16'hBC00, 4'h8, 16'hB791);
    vecs[13] = mk(4'hF, 4'h1, 1'b1, 16'h1234, 4'h1, 16'h3C00);
    vecs[14] = mk(4'h0, 4'h0, 1'b1, 16'h0000, 4'h2, 16'h4170);
    vecs[15] = mk(4'h0, 4'h0, 1'b0, 16'h0000, 4'h4, 16'h35E3);
    vecs[16] = mk(4'h0, 4'h0, 1'b0, 16'h0000, 4'h8, 16'hB791);
    vecs[17] = mk(4'h0, 4'h0, 1'b0, 16'h0000, 4'h1, 16'h3C00);
    vecs[18] = mk(4'h2, 4'h2, 1'b0, 16'h0000, 4'h0, 16'h3C00);
    vecs[19] = mk(4'hA, 4'h8, 1'b1, 16'h3C00, 4'h0, 16'h3C00);
    vecs[20] = mk(4'hA, 4'h2, 1'b1, 16'h1234, 4'h0, 16'h3C00);
    vecs[21] = mk(4'h0, 4'h0, 1'b1, 16'h3C00, 4'h0, 16'h3C00);
    vecs[22] = mk(4'h0, 4'h0, 1'b0, 16'h3C00, 4'h2, 16'h4170);
    vecs[23] = mk(4'h0, 4'h0, 1'b0, 16'h3C00, 4'h8, 16'hB791);
    vecs[24] = mk(4'h0, 4'h0, 1'b0, 16'h3C00, 4'h2, 16'h4170);
    vecs[25] = mk(4'hF, 4'h4, 1'b0, 16'h3C00, 4'h0, 16'h4170);
    vecs[26] = mk(4'h0, 4'h0, 1'b1, 16'hBC00, 4'h0, 16'h4170);
    vecs[27] = mk(4'h1, 4'h1, 1'b0, 16'hBC00, 4'h0, 16'h4170);
    vecs[28] = mk(4'h1, 4'h1, 1'b1, 16'h0000, 4'h0, 16'h4170);
    vecs[29] = mk(4'h1, 4'h1, 1'b1, 16'h0000, 4'h4, 16'h35E3);
    vecs[30] = mk(4'h1, 4'h0, 1'b1, 16'h0000, 4'h0, 16'h35E3);
    vecs[31] = mk(4'h1, 4'h0, 1'b0, 16'h0000, 4'h1, 16'h3C00);
    vecs[32] = mk(4'h1, 4'h1, 1'b0, 16'h0000, 4'h1, 16'h3C00);
    vecs[33] = mk(4'h1, 4'h1, 1'b1, 16'h0000, 4'h1, 16'h3C00);
    vecs[34] = mk(4'h1, 4'h1, 1'b1, 16'h0000, 4'h0, 16'h3C00);
    vecs[35] = mk(4'h1, 4'h0, 1'b1, 16'h0000, 4'h0, 16'h3C00);
    vecs[36] = mk(4'h1, 4'h0, 1'b0, 16'h0000, 4'h1, 16'h3C00);
    vecs[37] = mk(4'h1, 4'h1, 1'b0, 16'h0000, 4'h1, 16'h3C00);
    vecs[38] = mk(4'h0, 4'h0, 1'b1, 16'h0000, 4'h1, 16'h3C00);
    vecs[39] = mk(4'h0, 4'h0, 1'b0, 16'h0000, 4'h0, 16'h3C00);
    vecs[40] = mk(4'h0, 4'h0, 1'b0, 16'h0000, 4'h0, 16'h3C00);
    vecs[41] = mk(4'h0, 4'h0, 1'b0, 16'h0000, 4'h1, 16'h3C00);
    vecs[42] = mk(4'h0, 4'h0, 1'b0, 16'h0000, 4'h0, 16'h3C00);

    // Reset state, with requests asserted to show req_ready is held low.
    repeat (3) @(posedge clk);
    #1;
    rv_m = 4'hF;
    #1;
    chk("reset req_ready", 32'(rdy_m), 32'h0);
    chk("reset exp_in_valid", 32'(eiv_m), 32'h0);
    chk("reset exp_in", 32'(ei_m), 32'h0);
    chk("reset resp_valid", 32'(rspv_m), 32'h0);
    chk("reset resp_data", 32'(rspd_m), 32'h0);
    rv_m = 4'h0;
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      rv_m = vecs[i].rv;
      #1;
      chk($sformatf("row%0d req_ready", i), 32'(rdy_m), 32'(vecs[i].rdy));
      chk($sformatf("row%0d exp_in_valid", i), 32'(eiv_m), 32'(vecs[i].eiv));
      chk($sformatf("row%0d exp_in", i), 32'(ei_m), 32'(vecs[i].ei));
      chk($sformatf("row%0d resp_valid", i), 32'(rspv_m), 32'(vecs[i].rspv));
      chk($sformatf("row%0d resp_data", i), 32'(rspd_m), 32'(vecs[i].rspd));
    end

    // MAX_OUT=1, only lane 2: one grant every 5 cycles.
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      rv_l = 4'b0100;
      #1;
      chk($sformatf("lim%0d req_ready", k), 32'(rdy_l), (k % 5 == 0) ? 32'h4 : 32'h0);
      chk($sformatf("lim%0d resp_valid", k), 32'(rspv_l), (k % 5 == 4) ? 32'h4 : 32'h0);
      if (k % 5 == 4) begin
        chk($sformatf("lim%0d resp_data", k), 32'(rspd_l), 32'h35E3);
      end
    end
    @(posedge clk);
    #1;
    rv_l = 4'b0000;
`ifdef EXP_SHARE_STATS_EN
    chk("lim stat_issued", iss_l, 32'd4);
    chk("lim stat_stall", stl_l, 32'd16);
`endif

    // EXP_LAT=0: total latency exactly 2 cycles.
    @(posedge clk);
    #1;
    rv_z = 4'b0001;
    #1;
    chk("lat0 grant", 32'(rdy_z), 32'h1);
    @(posedge clk);
    #1;
    rv_z = 4'b0000;
    #1;
    chk("lat0 exp_in_valid", 32'(eiv_z), 32'h1);
    chk("lat0 exp_in", 32'(ei_z), 32'h3C00);
    chk("lat0 early resp_valid", 32'(rspv_z), 32'h0);
    @(posedge clk);
    #2;
    chk("lat0 resp_valid", 32'(rspv_z), 32'h1);
    chk("lat0 resp_data", 32'(rspd_z), 32'h4170);
    @(posedge clk);
    #2;
    chk("lat0 resp_valid drop", 32'(rspv_z), 32'h0);

    // Reset mid-flight on the default instance (rr_ptr is 1 here).
    @(posedge clk);
    #1;
    rv_m = 4'b0011;
    #1;
    chk("rst grant lane1", 32'(rdy_m), 32'h2);
    @(posedge clk);
    #1;
    rv_m = 4'b0001;
    #1;
    chk("rst grant lane0", 32'(rdy_m), 32'h1);
    @(posedge clk);
    #1;
    rv_m = 4'b0011;
    #1;
    reset = 1'b1;
    #1;
    chk("midrst req_ready", 32'(rdy_m), 32'h0);
    chk("midrst exp_in_valid", 32'(eiv_m), 32'h0);
    chk("midrst exp_in", 32'(ei_m), 32'h0);
    chk("midrst resp_valid", 32'(rspv_m), 32'h0);
    chk("midrst resp_data", 32'(rspd_m), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rv_m = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #2;
      chk($sformatf("postrst%0d resp_valid", k), 32'(rspv_m), 32'h0);
    end
    @(posedge clk);
    #1;
    rv_m = 4'b0011;
    #1;
    chk("postrst grant lane0", 32'(rdy_m), 32'h1);
    @(posedge clk);
    #1;
    rv_m = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
